// File: rtl/lzrw1_stream_parser.sv
// lzrw1_stream_parser: splits an LZRW1 byte stream into literal/copy items for a decompressor.
// Optional LZRW1_PARSER_ERR_CHECK_EN flags zero-offset copies and truncated blocks on err.
module lzrw1_stream_parser #(
  parameter int GROUP_SIZE = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] dec_data,
  output logic        dec_ctrl,
  output logic        dec_valid,
  input  logic        dec_busy,
  output logic        block_done,
  output logic        err
);
  typedef enum logic [2:0] {CTRL_LO, CTRL_HI, ITEM_B0, ITEM_B1, ISSUE} state_t;
  state_t      state, state_d;
  logic [15:0] ctrl, hold;
  logic [3:0]  idx;
  logic        hold_ctrl, last_pend, trunc_done;
  logic        fire, is_copy, end_grp, trunc, drop, xfer;
  assign in_ready   = !reset && state != ISSUE;
  assign fire       = in_valid && in_ready;
  assign is_copy    = ctrl[idx];
  assign end_grp    = idx == 4'(GROUP_SIZE - 1);
  assign xfer       = !reset && state == ISSUE && !dec_busy;
  assign dec_valid  = xfer;
  assign dec_data   = state == ISSUE ? hold : 16'h0000;
  assign dec_ctrl   = state == ISSUE && hold_ctrl;
  assign block_done = (xfer && last_pend) || trunc_done;
  assign trunc      = fire && in_last &&
                      (state == CTRL_LO || state == CTRL_HI || (state == ITEM_B0 && is_copy));
`ifdef LZRW1_PARSER_ERR_CHECK_EN
  logic err_q;
  assign drop = fire && state == ITEM_B1 && {hold[11:8], in_byte} == 12'd0;
  assign err  = err_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) err_q <= 1'b0;
    else if (trunc || drop) err_q <= 1'b1;
`else
  assign drop = 1'b0;
  assign err  = 1'b0;
`endif
  always_comb begin
    state_d = state;
    case (state)
      CTRL_LO: if (fire) state_d = in_last ? CTRL_LO : CTRL_HI;
      CTRL_HI: if (fire) state_d = in_last ? CTRL_LO : ITEM_B0;
      ITEM_B0: if (fire) state_d = !is_copy ? ISSUE : in_last ? CTRL_LO : ITEM_B1;
      ITEM_B1: if (fire) state_d = !drop ? ISSUE : (end_grp || in_last) ? CTRL_LO : ITEM_B0;
      ISSUE:   if (xfer) state_d = (end_grp || last_pend) ? CTRL_LO : ITEM_B0;
      default: state_d = CTRL_LO;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= CTRL_LO;
    else state <= state_d;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl       <= 16'h0000;
      hold       <= 16'h0000;
      idx        <= 4'd0;
      hold_ctrl  <= 1'b0;
      last_pend  <= 1'b0;
      trunc_done <= 1'b0;
    end else begin
      // a dropped item that ends the block still closes it
      trunc_done <= trunc || (drop && in_last);
      if (fire) begin
        case (state)
          CTRL_LO: ctrl[7:0] <= in_byte;
          CTRL_HI: begin
            ctrl[15:8] <= in_byte;
            idx        <= 4'd0;
          end
          ITEM_B0: if (!is_copy) begin
            hold      <= {8'h00, in_byte};
            hold_ctrl <= 1'b0;
            last_pend <= in_last;
          end else begin
            hold[15:8] <= in_byte;
            if (in_last) idx <= 4'd0;
          end
          ITEM_B1: begin
            hold[7:0] <= in_byte;
            hold_ctrl <= 1'b1;
            if (drop) idx <= (end_grp || in_last) ? 4'd0 : idx + 4'd1;
            else last_pend <= in_last;
          end
          default: ;
        endcase
      end
      if (xfer) begin
        idx       <= (end_grp || last_pend) ? 4'd0 : idx + 4'd1;
        last_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lzrw1_stream_parser.sv
// tb_lzrw1_stream_parser: directed vectors with hand-computed transfers for lzrw1_stream_parser.
module tb_lzrw1_stream_parser;
  logic        clock = 1'b0;
  logic        reset, in_valid, in_last, dec_busy;
  logic [7:0]  in_byte;
  logic        in_ready, dec_ctrl, dec_valid, block_done, err;
  logic [15:0] dec_data;
  int          n_tot = 0, n_bad = 0, n_done = 0, base = 0, d0;
  logic [16:0] xq[$];
  logic        dq[$];
  always #5 clock = ~clock;
  lzrw1_stream_parser #(.GROUP_SIZE(16)) dut (
    .clock(clock), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .dec_data(dec_data), .dec_ctrl(dec_ctrl), .dec_valid(dec_valid),
    .dec_busy(dec_busy), .block_done(block_done), .err(err)
  );
  always @(negedge clock) begin
    if (dec_valid) begin
      xq.push_back({dec_ctrl, dec_data});
      dq.push_back(block_done);
    end
    if (block_done) n_done++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic l);
    logic ok = 1'b0;
    in_byte = b; in_last = l; in_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock); #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask
  task automatic expect_n(input string tag, input int n);
    chk(tag, xq.size() - base, n);
  endtask
  initial begin
    reset = 1'b1; in_valid = 1'b1; in_byte = 8'hAA; in_last = 1'b0; dec_busy = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_data", dec_data, 0);
    chk("rst_dec_ctrl", dec_ctrl, 0);
    chk("rst_block_done", block_done, 0);
    chk("rst_err", err, 0);
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0;
    // sixteen literals fill a whole group
    send(8'h00, 0); send(8'h00, 0);
    for (int i = 0; i < 16; i++) send(8'h41 + 8'(i), 0);
    idle(3);
    expect_n("lit16_count", 16);
    for (int i = 0; i < 16; i++) chk($sformatf("lit16_%0d", i), xq[base+i], 17'h00041 + 17'(i));
    base = xq.size();
    // literal then copy; the 02 is taken as a fresh control word
    send(8'h02, 0); send(8'h00, 0); send(8'h61, 0); send(8'h30, 0); send(8'h05, 1);
    idle(3);
    expect_n("mix_count", 2);
    chk("mix_lit", xq[base], 17'h00061);
    chk("mix_copy", xq[base+1], 17'h13005);
    chk("mix_done", {dq[base], dq[base+1]}, 2'b01);
    base = xq.size();
    send(8'h00, 0); send(8'h00, 0); send(8'h78, 0); send(8'h79, 0); send(8'h7A, 1);
    idle(3);
    expect_n("last3_count", 3);
    chk("last3_data", xq[base+2], 17'h0007A);
    chk("last3_done", {dq[base], dq[base+1], dq[base+2]}, 3'b001);
    base = xq.size();
    // stall in ISSUE for four cycles
    dec_busy = 1'b1;
    send(8'h00, 0); send(8'h00, 0); send(8'h33, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("busy_valid", dec_valid, 0);
      chk("busy_ready", in_ready, 0);
      chk("busy_data", dec_data, 16'h0033);
      @(posedge clock); #1;
    end
    dec_busy = 1'b0;
    @(negedge clock);
    chk("busy_release", dec_valid, 1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("busy_once", dec_valid, 0);
    @(posedge clock); #1;
    send(8'h34, 1);
    idle(3);
    expect_n("busy_count", 2);
    chk("busy_second", xq[base+1], 17'h00034);
    base = xq.size();
    // truncated block inside a copy
    d0 = n_done;
    send(8'h01, 0); send(8'h00, 0); send(8'h44, 1);
    idle(2);
    expect_n("trunc_count", 0);
    chk("trunc_done", n_done - d0, 1);
`ifdef LZRW1_PARSER_ERR_CHECK_EN
    chk("trunc_err", err, 1);
`else
    chk("trunc_err", err, 0);
`endif
    send(8'h00, 0); send(8'h00, 0); send(8'h66, 1);
    idle(3);
    expect_n("after_trunc_count", 1);
    chk("after_trunc_data", xq[base], 17'h00066);
    base = xq.size();
    // zero-offset copy
    send(8'h01, 0); send(8'h00, 0); send(8'h20, 0); send(8'h00, 1);
    idle(3);
`ifdef LZRW1_PARSER_ERR_CHECK_EN
    expect_n("zoff_count", 0);
    chk("zoff_err", err, 1);
`else
    expect_n("zoff_count", 1);
    chk("zoff_data", xq[base], 17'h12000);
    chk("zoff_done", dq[base], 1);
`endif
    base = xq.size();
    // reset while waiting for the second copy byte
    send(8'h01, 0); send(8'h00, 0); send(8'h30, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_valid", dec_valid, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_err", err, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    send(8'h00, 0); send(8'h00, 0); send(8'h55, 1);
    idle(3);
    expect_n("midrst_count", 1);
    chk("midrst_data", xq[base], 17'h00055);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
